// File: rtl/systolic_feeder.sv
// Purpose : operand store plus skewed edge feeder for a 3x3 systolic multiplier.
// Latency : t=0 operands appear the cycle after start; 5 feed + 3 flush cycles, done on cycle 9.
// Backpr. : none; start and writes are dropped while busy, nothing is queued.
// Ports   : clock/rst_n (sync, active-low); wr_en/wr_sel/wr_row/wr_col/wr_data load A (sel=0)
//           or B (sel=1); start launches a sequence; busy/done/valid status; a_out0..2 feed the
//           west edge of rows 0..2, b_out0..2 feed the north edge of columns 0..2.
module systolic_feeder #(
  parameter int n = 31
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic         wr_sel,
  input  logic [1:0]   wr_row,
  input  logic [1:0]   wr_col,
  input  logic [n:0]   wr_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic [n:0]   a_out0,
  output logic [n:0]   a_out1,
  output logic [n:0]   a_out2,
  output logic [n:0]   b_out0,
  output logic [n:0]   b_out1,
  output logic [n:0]   b_out2
);

  localparam int DIM = 3;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH} state_t;

  state_t     r_state;
  logic [2:0] r_t;
  logic [n:0] r_a [DIM][DIM];
  logic [n:0] r_b [DIM][DIM];

  logic       w_wr_ok;
  logic       w_fwd_a;
  logic       w_fwd_b;
  logic [2:0] w_step;
  logic [n:0] w_a [DIM];
  logic [n:0] w_b [DIM];

  // The store only accepts in-range writes, and only while no sequence is running.
  assign w_wr_ok = wr_en && (r_state == S_IDLE) && (wr_row != 2'd3) && (wr_col != 2'd3);
  // A write to [0][0] landing on the start edge must be seen by the t=0 operand.
  assign w_fwd_a = w_wr_ok && !wr_sel && (wr_row == 2'd0) && (wr_col == 2'd0);
  assign w_fwd_b = w_wr_ok &&  wr_sel && (wr_row == 2'd0) && (wr_col == 2'd0);

  // Operands for the step being loaded: in IDLE that is t=0 (start edge), in FEED r_t.
  // Row i carries A[i][t-i], column j carries B[t-j][j]; out-of-window lanes are zero.
  always_comb begin
    w_step = (r_state == S_IDLE) ? 3'd0 : r_t;
    for (int i = 0; i < DIM; i++) begin
      w_a[i] = '0;
      w_b[i] = '0;
    end
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        if (w_step == 3'(i + k)) begin
          w_a[i] = r_a[i][k];
          w_b[i] = r_b[k][i];
        end
      end
    end
    if (r_state == S_IDLE) begin
      if (w_fwd_a) w_a[0] = wr_data;
      if (w_fwd_b) w_b[0] = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_t     <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      a_out0  <= '0;
      a_out1  <= '0;
      a_out2  <= '0;
      b_out0  <= '0;
      b_out1  <= '0;
      b_out2  <= '0;
      for (int i = 0; i < DIM; i++) begin
        for (int k = 0; k < DIM; k++) begin
          r_a[i][k] <= '0;
          r_b[i][k] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      if (w_wr_ok) begin
        if (wr_sel) r_b[wr_row][wr_col] <= wr_data;
        else        r_a[wr_row][wr_col] <= wr_data;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FEED;
            r_t     <= 3'd1;
            busy    <= 1'b1;
            valid   <= 1'b1;
            a_out0  <= w_a[0];
            a_out1  <= w_a[1];
            a_out2  <= w_a[2];
            b_out0  <= w_b[0];
            b_out1  <= w_b[1];
            b_out2  <= w_b[2];
          end
        end
        S_FEED: begin
          // r_t is the step being loaded; once t=4 is on the outputs (r_t=5) switch to flush.
          if (r_t == 3'd5) begin
            r_state <= S_FLUSH;
            r_t     <= 3'd0;
            valid   <= 1'b0;
            a_out0  <= '0;
            a_out1  <= '0;
            a_out2  <= '0;
            b_out0  <= '0;
            b_out1  <= '0;
            b_out2  <= '0;
          end else begin
            r_t    <= r_t + 3'd1;
            a_out0 <= w_a[0];
            a_out1 <= w_a[1];
            a_out2 <= w_a[2];
            b_out0 <= w_b[0];
            b_out1 <= w_b[1];
            b_out2 <= w_b[2];
          end
        end
        S_FLUSH: begin
          // Three zero cycles so the last operand pair reaches PE(2,2).
          if (r_t == 3'd2) begin
            r_state <= S_IDLE;
            r_t     <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_t <= r_t + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [1:0]  wr_row = 2'd0;
  logic [1:0]  wr_col = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        start = 1'b0;
  logic        busy, done, valid;
  logic [31:0] a_out0, a_out1, a_out2, b_out0, b_out1, b_out2;

  int vectors = 0;
  int miscompares = 0;

  // Expected edge traces for A=[[1..9]] and B=[[10..18]], t=0..4.
  int exp_a [5][3] = '{'{1,0,0}, '{2,4,0}, '{3,5,7}, '{0,6,8}, '{0,0,9}};
  int exp_b [5][3] = '{'{10,0,0}, '{13,11,0}, '{16,14,12}, '{0,17,15}, '{0,0,18}};

  systolic_feeder #(.n(31)) dut (
    .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .busy(busy), .done(done), .valid(valid),
    .a_out0(a_out0), .a_out1(a_out1), .a_out2(a_out2),
    .b_out0(b_out0), .b_out1(b_out1), .b_out2(b_out2)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [1:0] row, input logic [1:0] col,
                    input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_row = row; wr_col = col; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Pulses start and checks the whole sequence, returning in the done cycle.
  // zero: expect an all-zero store. blk: write A[0][0]=99 and hold start while busy.
  // fwd: write A[0][0]=a00 on the start cycle.
  task automatic run(input string tag, input logic [31:0] a00, input bit zero,
                     input bit blk, input bit fwd);
    logic [31:0] ea [3];
    logic [31:0] eb [3];
    start = 1'b1;
    if (fwd) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = a00;
    end
    tick();
    start = blk;
    wr_en = blk;
    if (blk) begin
      wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'd99;
    end
    for (int t = 0; t < 5; t++) begin
      for (int l = 0; l < 3; l++) begin
        ea[l] = zero ? 32'd0 : 32'(exp_a[t][l]);
        eb[l] = zero ? 32'd0 : 32'(exp_b[t][l]);
      end
      if (t == 0) ea[0] = a00;
      chk({tag, "_feed_flags"}, {93'd0, busy, done, valid}, 96'b101);
      chk({tag, "_a"}, {a_out0, a_out1, a_out2}, {ea[0], ea[1], ea[2]});
      chk({tag, "_b"}, {b_out0, b_out1, b_out2}, {eb[0], eb[1], eb[2]});
      tick();
    end
    for (int f = 0; f < 3; f++) begin
      chk({tag, "_flush_flags"}, {93'd0, busy, done, valid}, 96'b100);
      chk({tag, "_flush_ab"}, {a_out0, a_out1, a_out2, b_out0, b_out1, b_out2}, 96'd0);
      tick();
    end
    wr_en = 1'b0;
    chk({tag, "_done_flags"}, {93'd0, busy, done, valid}, 96'b010);
    chk({tag, "_done_ab"}, {a_out0, a_out1, a_out2, b_out0, b_out1, b_out2}, 96'd0);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    chk("rst_flags", {93'd0, busy, done, valid}, 96'd0);
    chk("rst_a", {a_out0, a_out1, a_out2}, 96'd0);
    chk("rst_b", {b_out0, b_out1, b_out2}, 96'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_flags", {93'd0, busy, done, valid}, 96'd0);

    // Load A and B.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        wr(1'b0, 2'(r), 2'(c), 32'(r * 3 + c + 1));
        wr(1'b1, 2'(r), 2'(c), 32'(r * 3 + c + 10));
      end
    end

    // Base run with a blocked write and start held high while busy, then a
    // back-to-back run launched from the done cycle.
    run("run1", 32'd1, 1'b0, 1'b1, 1'b0);
    run("run2", 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("after_done_flags", {93'd0, busy, done, valid}, 96'd0);

    // Write and start together: t=0 sees the new A[0][0].
    run("fwd", 32'd42, 1'b0, 1'b0, 1'b1);
    tick();
    wr(1'b0, 2'd0, 2'd0, 32'd1);

    // Out-of-range writes are ignored.
    wr(1'b0, 2'd3, 2'd0, 32'hDEADBEEF);
    wr(1'b1, 2'd1, 2'd3, 32'hDEADBEEF);
    run("oob", 32'd1, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset in the middle of FEED at t=2.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_a", {a_out0, a_out1, a_out2}, {32'd3, 32'd5, 32'd7});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_flags", {93'd0, busy, done, valid}, 96'd0);
    chk("midrst_ab", {a_out0, a_out1, a_out2, b_out0, b_out1, b_out2}, 96'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_no_done", {93'd0, busy, done, valid}, 96'd0);
    end
    run("cleared", 32'd0, 1'b1, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit side of the 3x3 systolic multiplier: stores operand matrices A and B, then drives the skewed operand wavefronts into the array's west (row) and north (column) edges.
- Matrices are loaded through a simple write port. A start pulse launches a feed sequence; a trailing zero flush lets the last products propagate through the PE grid.
- Sits directly in front of the PE array; edge outputs connect to the a/b inputs of the boundary PEs.

Parameters:
- n, 31, MSB index of every data word (data width n+1).
- DIM, 3, array dimension. Fixed localparam, not overridable; the port list is per-lane for 3 lanes.

Ports:
- clock  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- wr_en  input  1  write strobe for the operand store
- wr_sel  input  1  0 = matrix A, 1 = matrix B
- wr_row  input  2  row index 0..2
- wr_col  input  2  column index 0..2
- wr_data  input  n+1  element value
- start  input  1  launch request, single-cycle pulse
- busy  output  1  high while a sequence is in progress
- done  output  1  one-cycle completion pulse
- valid  output  1  high on cycles where the feed window is active
- a_out0, a_out1, a_out2  output  n+1 each  row-edge operands for array rows 0..2
- b_out0, b_out1, b_out2  output  n+1 each  column-edge operands for array columns 0..2

Behaviour:
- All outputs are registered. On reset: busy=0, done=0, valid=0, all a_out/b_out=0, all 18 stored elements cleared to 0, FSM in IDLE, t=0.
- FSM states are IDLE, FEED, FLUSH.
- IDLE:
  - wr_en stores wr_data at [wr_row][wr_col] of the matrix chosen by wr_sel.
  - A write with wr_row=3 or wr_col=3 is ignored.
  - start=1 moves to FEED; busy rises on the same edge.
- FEED:
  - Step counter t runs 0..4 (2*DIM-1 = 5 cycles); valid=1.
  - The output registers update on the edge that accepts start, so t=0 values are visible the cycle after start is sampled.
  - a_outi = A[i][t-i] when 0 <= t-i <= 2, else 0.
  - b_outj = B[t-j][j] when 0 <= t-j <= 2, else 0.
  - After t=4 the FSM moves to FLUSH.
- FLUSH:
  - Lasts 3 cycles; valid=0 and all a_out/b_out=0.
  - These cycles let the final operand pair reach PE(2,2).
  - On exit the FSM returns to IDLE, busy=0 and done=1 for exactly one cycle, the first IDLE cycle.
- Total busy duration is 8 cycles.
- wr_en while busy=1 is ignored; the store is frozen during a sequence.
- start while busy=1 is ignored and not queued.
- start in the done cycle is accepted normally, allowing back-to-back sequences with a 1-cycle gap.
- wr_en and start together in IDLE: the write commits on that edge. The t=0 outputs are loaded from the store including that write (write-forwarding). Forwarding applies only to element [0][0] paths read at t=0.
- Elements are passed unmodified; the block performs no arithmetic on data.
- rst_n low mid-sequence: next edge returns to IDLE with the reset values above, and no done pulse is generated.
- done never coincides with valid.

Test Plan:
- Load A=[[1,2,3],[4,5,6],[7,8,9]] and B=[[10,11,12],[13,14,15],[16,17,18]], pulse start -> outputs across feed cycles t=0..4:
  - t=0: a=(1,0,0), b=(10,0,0)
  - t=1: a=(2,4,0), b=(13,11,0)
  - t=2: a=(3,5,7), b=(16,14,12)
  - t=3: a=(0,6,8), b=(0,17,15)
  - t=4: a=(0,0,9), b=(0,0,18)
  - valid high for exactly these 5 cycles.
- Same run -> busy high for 8 consecutive cycles, 3 zero-flush cycles with valid=0, done=1 for one cycle immediately after, busy=0 on that cycle.
- Write A[0][0]=99 during FEED, then start a second sequence from the done cycle -> second run shows a_out0=1 at t=0 (blocked write), start accepted with 1-cycle gap, identical output trace.
- wr_en with A[0][0]=42 and start on the same cycle in IDLE -> a_out0=42 at t=0.
- Assert rst_n=0 at t=2 of FEED -> next cycle all outputs 0, busy=0, no done pulse ever; a following start after reload feeds zeros from the cleared store unless rewritten.
- Write with wr_row=3, value 0xDEADBEEF -> store unchanged, feed trace identical to the first scenario.
